// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM-to-RAM boot loader.
package rom_loader_pkg;

  // Bytes packed into one RAM word.
  localparam int WORD_BYTES = 4;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/rom_loader.sv
// Boot loader: streams bytes from a combinational ROM, packs them into
// little-endian 32-bit words and writes them to RAM, holding the CPU in
// reset until the whole image has been copied.
//
// RAM handshake: mem_write_enable is the valid. A write is accepted in any
// cycle where mem_write_enable and mem_ready are both high. While waiting,
// mem_write_address and mem_write_data stay stable; exactly one write is
// accepted per WRITE visit.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'd0,
  parameter logic [31:0] MAX_BYTES    = 32'd65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  input  logic        mem_ready,
  output logic        cpu_hold,
  output logic        loaded,
  output logic        error,
  output state_t      state_dbg
);

  state_t      state;
  state_t      next_state;
  logic [1:0]  lane;
  logic [31:0] pack;
  logic [31:0] byte_count;
  logic        last;

  // Decoded actions for the datapath register block.
  logic        load_start;
  logic        capture;
  logic        set_last;
  logic        accept;

  // State register; reset wins over everything, including a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    next_state       = state;
    load_start       = 1'b0;
    capture          = 1'b0;
    set_last         = 1'b0;
    accept           = 1'b0;
    mem_write_enable = 1'b0;
    cpu_hold         = 1'b1;
    loaded           = 1'b0;
    error            = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        // Running out of budget before the ROM says it is done drops the
        // partial word and aborts.
        if (!rom_done && byte_count == MAX_BYTES) begin
          next_state = ERROR;
        end else begin
          capture = 1'b1;
          if (rom_done) begin
            set_last   = 1'b1;
            next_state = WRITE;
          end else if (lane == 2'(WORD_BYTES - 1)) begin
            next_state = WRITE;
          end
        end
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        if (mem_ready) begin
          accept     = 1'b1;
          next_state = last ? DONE : FETCH;
        end
      end
      DONE: begin
        cpu_hold = 1'b0;
        loaded   = 1'b1;
        if (start) begin
          load_start = 1'b1;
          next_state = FETCH;
        end
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address counters, byte lane, packing register and end-of-image flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_address       <= 32'd0;
      mem_write_address <= BASE_ADDRESS;
      pack              <= 32'd0;
      lane              <= 2'd0;
      last              <= 1'b0;
      byte_count        <= 32'd0;
    end else begin
      if (load_start) begin
        rom_address       <= 32'd0;
        mem_write_address <= BASE_ADDRESS;
        pack              <= 32'd0;
        lane              <= 2'd0;
        last              <= 1'b0;
        byte_count        <= 32'd0;
      end
      if (capture) begin
        pack[{lane, 3'b000} +: 8] <= rom_byte;
        rom_address               <= rom_address + 32'd1;
        lane                      <= lane + 2'd1;
        byte_count                <= byte_count + 32'd1;
        if (set_last) begin
          last <= 1'b1;
        end
      end
      if (accept) begin
        mem_write_address <= mem_write_address + 32'(WORD_BYTES);
        lane              <= 2'd0;
        pack              <= 32'd0;
      end
    end
  end

  assign mem_write_data = pack;
  assign state_dbg      = state;

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'd0, the RAM byte address of the first word written.
REQ-002 SHALL have parameter MAX_BYTES, default 32'd65536, the byte-count limit before load aborts with an error.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE or DONE.
REQ-006 SHALL have port rom_address  output  32  byte address driven to the combinational ROM.
REQ-007 SHALL have port rom_byte  input  8  ROM data for rom_address, valid in the same cycle.
REQ-008 SHALL have port rom_done  input  1  high when rom_address is the last valid ROM byte.
REQ-009 SHALL have port mem_write_enable  output  1  RAM word-write request.
REQ-010 SHALL have port mem_write_address  output  32  RAM byte address, word-aligned.
REQ-011 SHALL have port mem_write_data  output  32  packed little-endian word.
REQ-012 SHALL have port mem_ready  input  1  RAM accepts the write in any cycle where mem_write_enable and mem_ready are both high.
REQ-013 SHALL have port cpu_hold  output  1  holds the CPU in reset until the load succeeds.
REQ-014 SHALL have port loaded  output  1  high in DONE.
REQ-015 SHALL have port error  output  1  high in ERROR.

Function
REQ-016 SHALL use FSM states IDLE, FETCH, WRITE, DONE and ERROR.
REQ-017 IDLE or DONE with start=1 SHALL move to FETCH and clear rom_address, byte lane and packing register to 0, with mem_write_address=BASE_ADDRESS; start is ignored in every other state.
REQ-018 FETCH SHALL capture rom_byte into lane[1:0] of the packing register each cycle (lane 0 = bits 7:0), then increment rom_address and lane.
REQ-019 FETCH SHALL go to WRITE after capturing lane 3, or after capturing any lane while rom_done=1; the latter also sets a last flag.
REQ-020 Unfilled lanes of a final partial word SHALL be zero.
REQ-021 WRITE SHALL hold mem_write_enable=1 with stable address and data until mem_ready=1.
REQ-022 On acceptance, WRITE SHALL add 4 to mem_write_address and clear the lane and packing register.
REQ-023 On acceptance, WRITE SHALL then go to DONE if last is set, else return to FETCH.
REQ-024 mem_write_enable SHALL be high only in WRITE; exactly one write SHALL be accepted per WRITE visit.
REQ-025 If a byte is captured with rom_done=0 and the running byte count equals MAX_BYTES, the block SHALL go to ERROR without writing that partial word.
REQ-026 ERROR SHALL be left only by reset.
REQ-027 Latency with mem_ready tied high: 5 cycles per full word, lane+2 cycles for a final partial word.
REQ-028 cpu_hold SHALL be 0 only in DONE; loaded SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-029 start in DONE SHALL reassert cpu_hold on the next cycle and reload from address 0.
REQ-030 rom_address and mem_write_address SHALL wrap modulo 2^32 without special handling.

Reset
REQ-031 reset=1 SHALL force IDLE in the same edge regardless of state, including mid-WRITE; no write is completed afterward.
REQ-032 Reset values: rom_address=0, mem_write_address=BASE_ADDRESS, mem_write_data=0, mem_write_enable=0, cpu_hold=1, loaded=0, error=0, last=0, lane=0, byte count=0.

Structure
REQ-033 Package rom_loader_pkg SHALL hold the state typedef (IDLE, FETCH, WRITE, DONE, ERROR) and constant WORD_BYTES=4.
REQ-034 The block SHALL be a single module with no sub-modules.
REQ-035 The ROM SHALL be instantiated beside rom_loader by the parent, not inside it.

Verification
REQ-036 Reset then start, mem_ready=1, with the 118-byte program ROM (done at 117) -> first write addr 0x0 data 0x000F140E; 30 writes total; last write addr 0x74 data 0x00000000; loaded=1, cpu_hold=0 at cycle 149 after start.
REQ-037 Same load with mem_ready low for 3 cycles on the 2nd write -> addr 0x4 and data 0x00000000 held stable for 4 cycles; final results unchanged.
REQ-038 ROM of 5 bytes (done at 4, byte 4=0xAB) -> two writes; second is addr 0x4 data 0x000000AB.
REQ-039 ROM never asserting rom_done, MAX_BYTES=8 -> two writes, then error=1, cpu_hold=1, loaded=0; start is ignored.
REQ-040 reset asserted mid-WRITE with mem_ready=0 -> next cycle mem_write_enable=0, cpu_hold=1, rom_address=0; a new start reloads from address 0.
REQ-041 start in DONE -> cpu_hold=1 on the next cycle, and write 0 at BASE_ADDRESS repeats with the same data.
